cond_evaluator: RTL and testbench

Reads the four-bit condition-flag vector {Z,C,N,V} produced by the flag register and decides whether the current instruction's 4-bit ARM condition field passes. Sits in the control unit between the flag register and the execute-stage sequencer. Runs a start/done handshake with the sequencer. Waits one settle cycle so that a flag write issued on the same edge as START is observed before evaluation.

---
 rtl/cond_evaluator.sv | 98 +++++++++
 tb/tb_cond_evaluator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cond_evaluator.sv
// ARM condition-field evaluator with a start/done handshake and one settle cycle before FLAGS are sampled.
// Optional saturating skip counter enabled by defining COND_EVAL_SKIP_CNT_EN.
module cond_evaluator (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [3:0] COND,
  input  logic [3:0] FLAGS,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [7:0] SKIP_COUNT
);

  typedef enum logic [1:0] {IDLE, SETTLE, EVAL} state_t;

  state_t     state;
  logic [3:0] cond_q;
  logic       pass_now;
  logic       flag_z, flag_c, flag_n, flag_v;

  assign flag_z = FLAGS[3];
  assign flag_c = FLAGS[2];
  assign flag_n = FLAGS[1];
  assign flag_v = FLAGS[0];

  always_comb begin
    pass_now = 1'b0;
    case (cond_q)
      4'h0: pass_now = flag_z;
      4'h1: pass_now = !flag_z;
      4'h2: pass_now = flag_c;
      4'h3: pass_now = !flag_c;
      4'h4: pass_now = flag_n;
      4'h5: pass_now = !flag_n;
      4'h6: pass_now = flag_v;
      4'h7: pass_now = !flag_v;
      4'h8: pass_now = flag_c & !flag_z;
      4'h9: pass_now = !flag_c | flag_z;
      4'hA: pass_now = (flag_n == flag_v);
      4'hB: pass_now = (flag_n != flag_v);
      4'hC: pass_now = !flag_z & (flag_n == flag_v);
      4'hD: pass_now = flag_z | (flag_n != flag_v);
      4'hE: pass_now = 1'b1;
      default: pass_now = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      cond_q <= 4'h0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      PASS   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            cond_q <= COND;
            BUSY   <= 1'b1;
            state  <= SETTLE;
          end
        end
        // FLAGS deliberately ignored here so a same-edge flag write lands first.
        SETTLE: state <= EVAL;
        EVAL: begin
          PASS  <= pass_now;
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef COND_EVAL_SKIP_CNT_EN
  logic [7:0] skip_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      skip_q <= 8'h00;
    end else if (state == EVAL && !pass_now && skip_q != 8'hFF) begin
      skip_q <= skip_q + 8'h01;
    end
  end

  assign SKIP_COUNT = skip_q;
`else
  assign SKIP_COUNT = 8'h00;
`endif

endmodule

// File: tb/tb_cond_evaluator.sv
// Randomized bench for cond_evaluator against a transaction-level condition model.
// Honors COND_EVAL_SKIP_CNT_EN the same way the design does.
module tb_cond_evaluator;

  logic       CLK = 1'b0;
  logic       RESET, START;
  logic [3:0] COND, FLAGS;
  logic       BUSY, DONE, PASS;
  logic [7:0] SKIP_COUNT;

  int errors = 0;
  int checks = 0;
  int skip_n = 0;
  logic last_pass = 1'b0;

  always #5 CLK = ~CLK;

  cond_evaluator dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .COND       (COND),
    .FLAGS      (FLAGS),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .PASS       (PASS),
    .SKIP_COUNT (SKIP_COUNT)
  );

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  // Conditions come in true/inverted pairs; bit 0 of the field selects the inversion.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic z, cy, n, v, base;
    z = f[3]; cy = f[2]; n = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic int exp_skip();
`ifdef COND_EVAL_SKIP_CNT_EN
    return (skip_n > 255) ? 255 : skip_n;
`else
    return 0;
`endif
  endfunction

  // Entered at a negedge; returns at the negedge where DONE is observed.
  task automatic run_eval(input logic [3:0] c, input logic [3:0] f0, input logic [3:0] f1,
                          input bit late, input bit drop, input logic [3:0] drop_cond);
    logic p;
    int n;
    START = 1'b1;
    COND  = c;
    FLAGS = f0;
    @(posedge CLK);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (n == 1) begin
        START = drop;
        COND  = drop ? drop_cond : 4'($urandom());
        if (late) FLAGS = f1;
      end else if (n == 2) begin
        START = 1'b0;
      end
      if (!DONE) chk("busy_inflight", int'(BUSY), 1);
    end while (!DONE && n < 8);
    p = ref_pass(c, late ? f1 : f0);
    if (!p) skip_n++;
    last_pass = p;
    chk("latency", n, 3);
    chk("done", int'(DONE), 1);
    chk("busy_with_done", int'(BUSY), 0);
    chk("pass", int'(PASS), int'(p));
    chk("skip_count", int'(SKIP_COUNT), exp_skip());
    FLAGS = 4'($urandom());
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      START = 1'b0;
      chk("idle_done", int'(DONE), 0);
      chk("idle_busy", int'(BUSY), 0);
      chk("pass_hold", int'(PASS), int'(last_pass));
      chk("idle_skip", int'(SKIP_COUNT), exp_skip());
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    skip_n = 0;
    last_pass = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    COND  = 4'h0;
    FLAGS = 4'h0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_pass", int'(PASS), 0);
    chk("rst_skip", int'(SKIP_COUNT), 0);
    RESET = 1'b0;
    idle(1);

    // EQ pass then fail
    run_eval(4'h0, 4'b1000, 4'b1000, 0, 0, 4'h0);
    chk("eq_pass", int'(PASS), 1);
    idle(2);
    run_eval(4'h0, 4'b0000, 4'b0000, 0, 0, 4'h0);
    chk("eq_fail", int'(PASS), 0);
    idle(2);

    // GE with N changing during SETTLE
    run_eval(4'hA, 4'b0010, 4'b0011, 1, 0, 4'h0);
    chk("late_flag", int'(PASS), 1);
    idle(2);

    // AL with an NV request dropped while busy
    run_eval(4'hE, 4'b0000, 4'b0000, 0, 1, 4'hF);
    chk("drop_pass", int'(PASS), 1);
    idle(4);

    // HI then LS accepted in the DONE cycle
    run_eval(4'h8, 4'b0100, 4'b0100, 0, 0, 4'h0);
    chk("b2b_hi", int'(PASS), 1);
    run_eval(4'h9, 4'b0100, 4'b0100, 0, 0, 4'h0);
    chk("b2b_ls", int'(PASS), 0);
    idle(2);

    // Reset while in SETTLE
    START = 1'b1;
    COND  = 4'h0;
    FLAGS = 4'b1000;
    @(negedge CLK);
    START = 1'b0;
    chk("pre_abort_busy", int'(BUSY), 1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(DONE), 0);
    chk("abort_pass", int'(PASS), 0);
    skip_n = 0;
    last_pass = 1'b0;
    chk("abort_skip", int'(SKIP_COUNT), 0);
    idle(6);

    for (int i = 0; i < 60; i++) begin
      bit b2b;
      run_eval(4'($urandom()), 4'($urandom()), 4'($urandom()),
               1'($urandom()), 1'($urandom()), 4'($urandom()));
      b2b = ($urandom_range(0, 2) == 0);
      if (!b2b) idle(int'($urandom_range(1, 3)));
    end
    idle(1);

    // Saturation: 260 NV evaluations from a clean counter
    do_reset();
    idle(1);
    for (int i = 0; i < 260; i++) begin
      run_eval(4'hF, 4'($urandom()), 4'($urandom()), 0, 0, 4'h0);
    end
    idle(2);
`ifdef COND_EVAL_SKIP_CNT_EN
    chk("skip_sat", int'(SKIP_COUNT), 255);
`else
    chk("skip_tied", int'(SKIP_COUNT), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
